core_mrpnwp_wr_arb: RTL and testbench

- Write-side controller for the multi-port 1r1w memory core.
- After reset it runs an init sequencer that writes INITVAL to every physical address, then raises ready.
- After init it round-robin arbitrates NUMWRPT write requesters onto the single physical write port, one write per cycle, with registered outputs.
- A runtime clear request re-enters the init sequence.

---
 rtl/core_mrpnwp_pkg.sv | 34 +++
 rtl/core_mrpnwp_rr_arb.sv | 33 +++
 rtl/core_mrpnwp_wr_arb.sv | 123 ++++++++++++
 tb/tb_core_mrpnwp_wr_arb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mrpnwp_pkg.sv
// Shared types and the round-robin pick helper for the write-side arbiter.
package core_mrpnwp_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int RR_MAX_PT = 16;
  localparam int RR_IDX_W  = 4;

  // Index of the first set request scanning upward from ptr, modulo n.
  // ptr must be below n; lanes at or above n are ignored.
  function automatic int rr_pick(input logic [RR_MAX_PT-1:0] req,
                                 input int n,
                                 input int ptr);
    int   idx;
    int   win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_PT; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[RR_IDX_W-1:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/core_mrpnwp_rr_arb.sv
// Combinational round-robin picker: one-hot grant and winner index from the
// request vector and the current priority pointer.
module core_mrpnwp_rr_arb
  import core_mrpnwp_pkg::*;
#(
  parameter int NUMWRPT = 3,
  parameter int BITWRPT = 2
) (
  input  logic [NUMWRPT-1:0] i_req,
  input  logic [BITWRPT-1:0] i_rr_ptr,
  output logic [NUMWRPT-1:0] o_gnt,
  output logic [BITWRPT-1:0] o_winner,
  output logic               o_any_req
);

  logic [RR_MAX_PT-1:0] w_req_ext;
  int                   w_win;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUMWRPT-1:0] = i_req;
    w_win                  = rr_pick(w_req_ext, NUMWRPT, int'(i_rr_ptr));
  end

  assign o_winner  = BITWRPT'(w_win);
  assign o_any_req = |i_req;

  always_comb begin
    o_gnt = '0;
    if (o_any_req) o_gnt[o_winner] = 1'b1;
  end

endmodule

// File: rtl/core_mrpnwp_wr_arb.sv
// Write-side controller: init sweep after reset or clear, then round-robin
// arbitration of NUMWRPT requesters onto one registered physical write port.
//   state | meaning
//   RST   | held in reset / first cycle after release
//   INIT  | sweeping INITVAL across every physical address
//   RUN   | arbitrating requesters, one write per cycle
module core_mrpnwp_wr_arb
  import core_mrpnwp_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               NUMWRPT = 3,
  parameter int               BITWRPT = 2,
  parameter int               NUMADDR = 8192,
  parameter int               BITADDR = 13,
  parameter bit               INITEN  = 1'b1,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUMWRPT-1:0]         i_req,
  input  logic [NUMWRPT*BITADDR-1:0] i_req_addr,
  input  logic [NUMWRPT*WIDTH-1:0]   i_req_din,
  output logic [NUMWRPT-1:0]         o_req_gnt,
  input  logic                       i_clr,
  output logic                       o_pwrite,
  output logic [BITADDR-1:0]         o_pwraddr,
  output logic [WIDTH-1:0]           o_pdin,
  output logic                       o_ready,
  output logic                       o_busy
);

  state_t               r_state;
  state_t               w_next_state;
  logic [BITWRPT-1:0]   r_rr_ptr;
  logic [BITADDR-1:0]   r_init_cnt;
  logic                 r_pwrite;
  logic [BITADDR-1:0]   r_pwraddr;
  logic [WIDTH-1:0]     r_pdin;

  logic [NUMWRPT-1:0]   w_arb_gnt;
  logic [BITWRPT-1:0]   w_winner;
  logic                 w_any_req;
  logic                 w_grant;
  logic                 w_init_last;
  logic [BITADDR-1:0]   w_sel_addr;
  logic [WIDTH-1:0]     w_sel_din;

  core_mrpnwp_rr_arb #(
    .NUMWRPT (NUMWRPT),
    .BITWRPT (BITWRPT)
  ) u_rr_arb (
    .i_req     (i_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt     (w_arb_gnt),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_init_last = (r_init_cnt == BITADDR'(NUMADDR - 1));
  assign w_sel_addr  = i_req_addr[w_winner*BITADDR +: BITADDR];
  assign w_sel_din   = i_req_din[w_winner*WIDTH +: WIDTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= RST;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RST:     w_next_state = INITEN ? INIT : RUN;
      INIT:    if (w_init_last) w_next_state = RUN;
      RUN:     if (i_clr) w_next_state = INIT;
      default: w_next_state = RST;
    endcase
  end

  // clr wins over arbitration, so pending requests simply wait out the sweep.
  always_comb begin
    o_ready   = (r_state == RUN);
    o_busy    = (r_state == INIT);
    w_grant   = (r_state == RUN) && !i_clr && w_any_req;
    o_req_gnt = w_grant ? w_arb_gnt : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pwrite   <= 1'b0;
      r_pwraddr  <= '0;
      r_pdin     <= '0;
      r_rr_ptr   <= '0;
      r_init_cnt <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_pwrite   <= 1'b1;
          r_pwraddr  <= r_init_cnt;
          r_pdin     <= INITVAL;
          r_init_cnt <= w_init_last ? '0 : r_init_cnt + 1'b1;
        end
        RUN: begin
          if (i_clr) begin
            r_pwrite   <= 1'b0;
            r_init_cnt <= '0;
          end else if (w_grant) begin
            r_pwrite  <= 1'b1;
            r_pwraddr <= w_sel_addr;
            r_pdin    <= w_sel_din;
            r_rr_ptr  <= (w_winner == BITWRPT'(NUMWRPT - 1)) ? '0 : w_winner + 1'b1;
          end else begin
            r_pwrite <= 1'b0;
          end
        end
        default: r_pwrite <= 1'b0;
      endcase
    end
  end

  assign o_pwrite  = r_pwrite;
  assign o_pwraddr = r_pwraddr;
  assign o_pdin    = r_pdin;

endmodule

// File: tb/tb_core_mrpnwp_wr_arb.sv
// Scoreboard bench: two arbiter instances (init sweep enabled with 8 addresses,
// init sweep disabled with 5 addresses) against a cycle-level reference model.
module tb_core_mrpnwp_wr_arb;

  localparam int M_RST  = 0;
  localparam int M_INIT = 1;
  localparam int M_RUN  = 2;

  localparam int G_IDLE   = 0;
  localparam int G_ALL    = 1;
  localparam int G_P0     = 2;
  localparam int G_SPARSE = 3;
  localparam int G_CLR011 = 4;
  localparam int G_RAND   = 5;
  localparam int G_HOLD   = 6;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  logic        clk;
  logic        rst_v;
  logic [2:0]  req_v     [2];
  logic [8:0]  addr_v    [2];
  logic [95:0] din_v     [2];
  logic        clr_v     [2];
  logic [2:0]  gnt_o     [2];
  logic        pwrite_o  [2];
  logic [2:0]  pwraddr_o [2];
  logic [31:0] pdin_o    [2];
  logic        ready_o   [2];
  logic        busy_o    [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int gen_mode = G_IDLE;

  wr_t q0[$];
  wr_t q1[$];

  int         mmode [2];
  int         mptr  [2];
  int         midx  [2];
  bit         mprst [2];
  logic [2:0] gnt_seen [2];
  bit         pend [2][3];
  logic [2:0] paddr [2][3];
  logic [31:0] pdat [2][3];

  core_mrpnwp_wr_arb #(
    .WIDTH(32), .NUMWRPT(3), .BITWRPT(2), .NUMADDR(8), .BITADDR(3),
    .INITEN(1'b1), .INITVAL(32'h0000_DEAD)
  ) dut_a (
    .i_clk(clk), .i_rst(rst_v), .i_req(req_v[0]), .i_req_addr(addr_v[0]),
    .i_req_din(din_v[0]), .o_req_gnt(gnt_o[0]), .i_clr(clr_v[0]),
    .o_pwrite(pwrite_o[0]), .o_pwraddr(pwraddr_o[0]), .o_pdin(pdin_o[0]),
    .o_ready(ready_o[0]), .o_busy(busy_o[0])
  );

  core_mrpnwp_wr_arb #(
    .WIDTH(32), .NUMWRPT(3), .BITWRPT(2), .NUMADDR(5), .BITADDR(3),
    .INITEN(1'b0), .INITVAL(32'h0BAD_F00D)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_v), .i_req(req_v[1]), .i_req_addr(addr_v[1]),
    .i_req_din(din_v[1]), .o_req_gnt(gnt_o[1]), .i_clr(clr_v[1]),
    .o_pwrite(pwrite_o[1]), .o_pwraddr(pwraddr_o[1]), .o_pdin(pdin_o[1]),
    .o_ready(ready_o[1]), .o_busy(busy_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int na(input int u);
    return (u == 0) ? 8 : 5;
  endfunction

  function automatic logic [31:0] ival(input int u);
    return (u == 0) ? 32'h0000_DEAD : 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, u, cyc, act, exp);
    end
  endtask

  task automatic push(input int u, input logic [2:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.due  = cyc + 1;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Reference model: checks this cycle's combinational outputs, then predicts
  // what the coming clock edge does.
  task automatic model_step(input int u);
    logic [2:0] exp_g;
    int w;
    int p;
    exp_g = '0;
    w = -1;
    if (mmode[u] == M_RUN && !clr_v[u]) begin
      for (int k = 0; k < 3; k++) begin
        p = (mptr[u] + k) % 3;
        if (w < 0 && req_v[u][p]) w = p;
      end
      if (w >= 0) exp_g[w] = 1'b1;
    end
    chk("gnt",   u, 32'(gnt_o[u]),   32'(exp_g));
    chk("ready", u, 32'(ready_o[u]), 32'(mmode[u] == M_RUN));
    chk("busy",  u, 32'(busy_o[u]),  32'(mmode[u] == M_INIT));
    if (mprst[u]) begin
      chk("rst_addr", u, 32'(pwraddr_o[u]), 32'd0);
      chk("rst_din",  u, pdin_o[u],         32'd0);
    end
    mprst[u] = 1'b0;
    if (!rst_v) begin
      mmode[u] = M_RST;
      mptr[u]  = 0;
      midx[u]  = 0;
      mprst[u] = 1'b1;
    end else begin
      case (mmode[u])
        M_RST: mmode[u] = (u == 0) ? M_INIT : M_RUN;
        M_INIT: begin
          push(u, 3'(midx[u]), ival(u));
          midx[u]++;
          if (midx[u] == na(u)) begin
            midx[u]  = 0;
            mmode[u] = M_RUN;
          end
        end
        default: begin
          if (clr_v[u]) begin
            mmode[u] = M_INIT;
            midx[u]  = 0;
          end else if (w >= 0) begin
            push(u, addr_v[u][w*3 +: 3], din_v[u][w*32 +: 32]);
            mptr[u] = (w + 1) % 3;
          end
        end
      endcase
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      mmode[u] = M_RST;
      mptr[u]  = 0;
      midx[u]  = 0;
      mprst[u] = 1'b0;
      gnt_seen[u] = '0;
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      gnt_seen[u] = gnt_o[u];
      model_step(u);
    end
  end

  // Monitor: every physical write must match the oldest expected write due now.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      wr_t e;
      bit have;
      have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (u == 0) ? q0[0] : q1[0];
      if (pwrite_o[u]) begin
        checks++;
        if (!have || e.due != cyc) begin
          errors++;
          $display("FAIL wr_unexp inst%0d cyc %0d: got write addr %0h din %0h, expected none",
                   u, cyc, pwraddr_o[u], pdin_o[u]);
        end else begin
          if (u == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          if (pwraddr_o[u] !== e.addr || pdin_o[u] !== e.data) begin
            errors++;
            $display("FAIL wr_data inst%0d cyc %0d: got addr %0h din %0h expected addr %0h din %0h",
                     u, cyc, pwraddr_o[u], pdin_o[u], e.addr, e.data);
          end
        end
      end else if (have && e.due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL wr_missing inst%0d cyc %0d: got no write expected addr %0h din %0h",
                 u, cyc, e.addr, e.data);
        if (u == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  end

  task automatic update_drivers();
    for (int u = 0; u < 2; u++) begin
      clr_v[u] = 1'b0;
      for (int p = 0; p < 3; p++) begin
        if (gnt_seen[u][p]) pend[u][p] = 1'b0;
        case (gen_mode)
          G_ALL: begin
            pend[u][p] = 1'b1; paddr[u][p] = 3'(p); pdat[u][p] = 32'(100 + p);
          end
          G_P0: begin
            pend[u][p] = (p == 0); paddr[u][p] = 3'(p + 1); pdat[u][p] = 32'(150 + p);
          end
          G_SPARSE: begin
            pend[u][p] = (p != 1); paddr[u][p] = 3'(p + 2); pdat[u][p] = 32'(200 + p);
          end
          G_CLR011: begin
            pend[u][p] = (p != 2); paddr[u][p] = 3'(p + 4); pdat[u][p] = 32'(300 + p);
          end
          G_RAND: begin
            if (!pend[u][p] && $urandom_range(0, 2) == 0) begin
              pend[u][p]  = 1'b1;
              paddr[u][p] = 3'($urandom_range(0, 7));
              pdat[u][p]  = $urandom;
            end else if (pend[u][p] && $urandom_range(0, 29) == 0) begin
              pend[u][p] = 1'b0;
            end
          end
          G_HOLD: ;
          default: pend[u][p] = 1'b0;
        endcase
        req_v[u][p]           = pend[u][p];
        addr_v[u][p*3 +: 3]   = paddr[u][p];
        din_v[u][p*32 +: 32]  = pdat[u][p];
      end
      if (gen_mode == G_RAND) clr_v[u] = ($urandom_range(0, 49) == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    update_drivers();
  endtask

  task automatic wait_ready(input int u, input string name);
    int n;
    n = 0;
    while (!ready_o[u] && n < 30) begin
      tick();
      n++;
    end
    chk(name, u, 32'(ready_o[u]), 32'd1);
  endtask

  initial begin
    rst_v = 1'b0;
    for (int u = 0; u < 2; u++) begin
      for (int p = 0; p < 3; p++) begin
        pend[u][p] = 1'b0; paddr[u][p] = '0; pdat[u][p] = '0;
      end
      req_v[u] = '0; addr_v[u] = '0; din_v[u] = '0; clr_v[u] = 1'b0;
    end
    gen_mode = G_IDLE;
    repeat (3) tick();
    rst_v = 1'b1;
    wait_ready(0, "init_done");
    repeat (2) tick();

    gen_mode = G_ALL;
    repeat (9) tick();
    gen_mode = G_IDLE;
    repeat (2) tick();

    gen_mode = G_P0;
    tick();
    gen_mode = G_IDLE;
    repeat (2) tick();
    gen_mode = G_SPARSE;
    repeat (4) tick();
    gen_mode = G_IDLE;
    tick();

    gen_mode = G_CLR011;
    tick();
    clr_v[0] = 1'b1;
    clr_v[1] = 1'b1;
    tick();
    wait_ready(0, "clr_done");
    repeat (4) tick();

    gen_mode = G_RAND;
    for (int i = 0; i < 300; i++) begin
      tick();
      rst_v = ($urandom_range(0, 199) != 0);
    end
    rst_v = 1'b1;

    gen_mode = G_IDLE;
    tick();
    wait_ready(0, "rand_done");
    tick();
    clr_v[0] = 1'b1;
    tick();
    repeat (5) tick();
    rst_v = 1'b0;
    tick();
    rst_v = 1'b1;
    repeat (12) tick();

    rst_v = 1'b0;
    tick();
    rst_v = 1'b1;
    tick();
    gen_mode = G_HOLD;
    tick();
    pend[1][2] = 1'b1; paddr[1][2] = 3'd7; pdat[1][2] = 32'h55;
    req_v[1][2] = 1'b1; addr_v[1][8:6] = 3'd7; din_v[1][95:64] = 32'h55;
    repeat (3) tick();

    gen_mode = G_IDLE;
    repeat (12) tick();
    chk("q_left", 0, 32'(q0.size()), 32'd0);
    chk("q_left", 1, 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
